// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: the bus around the ID/EX pipeline register.
//   Decode side   : in_valid/in_ready handshake, source/destination indices,
//                   register-file read data, immediate, ALU op and control bits.
//   Bypass side   : EX/MEM and MEM/WB destination, write-enable and result.
//   Execute side  : out_valid/out_ready handshake, forwarded ALU operands,
//                   ALU control, store data, destination and control bits.
// Modports: slave = the pipeline stage, master = the surrounding pipeline/bench.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rd_addr;
  logic              alu_src_imm;
  logic [3:0]        alu_ctrl_in;
  logic              reg_write_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              branch_in;
  logic              flush;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [XLEN-1:0]   exmem_result;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_reg_write;
  logic [XLEN-1:0]   memwb_result;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   store_data;
  logic [REG_AW-1:0] rd_out;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, rd_addr,
           alu_src_imm, alu_ctrl_in, reg_write_in, mem_read_in, mem_write_in,
           branch_in, flush, exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, rd_out,
           reg_write, mem_read, mem_write, branch
  );

  modport master (
    output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, rd_addr,
           alu_src_imm, alu_ctrl_in, reg_write_in, mem_read_in, mem_write_in,
           branch_in, flush, exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, rd_out,
           reg_write, mem_read, mem_write, branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry decode->execute pipeline register with operand
// forwarding, feeding the ALU.
//   clk, reset : clock, synchronous active-high reset
//   bus        : id_ex_stage_if.slave (decode handshake + fields, bypass
//                results, execute handshake + ALU operands/controls)
// Forwarding is combinational on the held entry; while the entry stalls the
// held operand data is refreshed with the forwarded values so a producer that
// retires out of MEM/WB during the stall is not lost.

// Single-source bypass mux: EX/MEM beats MEM/WB, x0 is never forwarded.
module id_ex_fwd #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   src_data,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   fwd_data
);
  logic nz;
  assign nz = |src_addr;

  always_comb begin
    fwd_data = src_data;
    if (nz && exmem_reg_write && exmem_rd == src_addr)
      fwd_data = exmem_result;
    else if (nz && memwb_reg_write && memwb_rd == src_addr)
      fwd_data = memwb_result;
  end
endmodule

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0][XLEN-1:0]   src_data;
    logic [XLEN-1:0]                imm;
    logic [REG_AW-1:0]              rd;
    logic                           alu_src_imm;
    logic [3:0]                     alu_ctrl;
    logic                           reg_write;
    logic                           mem_read;
    logic                           mem_write;
    logic                           branch;
  } entry_t;

  entry_t                       held;
  entry_t                       incoming;
  logic                         vld;
  logic                         load;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd;

  assign incoming = '{
    src_addr:    {bus.rs2_addr, bus.rs1_addr},
    src_data:    {bus.rs2_data, bus.rs1_data},
    imm:         bus.imm,
    rd:          bus.rd_addr,
    alu_src_imm: bus.alu_src_imm,
    alu_ctrl:    bus.alu_ctrl_in,
    reg_write:   bus.reg_write_in,
    mem_read:    bus.mem_read_in,
    mem_write:   bus.mem_write_in,
    branch:      bus.branch_in
  };

  // Index 0 = rs1, index 1 = rs2.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
      .src_addr        (held.src_addr[s]),
      .src_data        (held.src_data[s]),
      .exmem_rd        (bus.exmem_rd),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_result    (bus.exmem_result),
      .memwb_rd        (bus.memwb_rd),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_result    (bus.memwb_result),
      .fwd_data        (fwd[s])
    );
  end

  assign bus.in_ready = reset | ~vld | bus.out_ready;
  assign load         = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      held <= '0;
    end else if (bus.flush) begin
      // Drop both the held entry and whatever is offered; fields stay.
      vld <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      held <= incoming;
    end else if (vld && bus.out_ready) begin
      vld <= 1'b0;
    end else if (vld) begin
      // Stalled: latch forwarded values so late producers are retained.
      held.src_data <= fwd;
    end
  end

  assign bus.out_valid  = vld;
  assign bus.alu_a      = fwd[0];
  assign bus.alu_b      = held.alu_src_imm ? held.imm : fwd[1];
  assign bus.store_data = fwd[1];
  assign bus.alu_ctrl   = held.alu_ctrl;
  assign bus.rd_out     = held.rd;
  assign bus.reg_write  = held.reg_write;
  assign bus.mem_read   = held.mem_read;
  assign bus.mem_write  = held.mem_write;
  assign bus.branch     = held.branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, stall
// refresh, flush, reset-mid-stall and back-to-back throughput.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic [31:0] im, input logic [4:0] rd,
                       input logic src_imm, input logic [3:0] ctrl);
    bus.in_valid    = 1'b1;
    bus.rs1_addr    = r1;
    bus.rs1_data    = d1;
    bus.rs2_addr    = r2;
    bus.rs2_data    = d2;
    bus.imm         = im;
    bus.rd_addr     = rd;
    bus.alu_src_imm = src_imm;
    bus.alu_ctrl_in = ctrl;
  endtask

  task automatic no_fwd();
    bus.exmem_rd = '0; bus.exmem_reg_write = 1'b0; bus.exmem_result = '0;
    bus.memwb_rd = '0; bus.memwb_reg_write = 1'b0; bus.memwb_result = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.imm = '0; bus.rd_addr = '0; bus.alu_src_imm = 1'b0; bus.alu_ctrl_in = '0;
    bus.reg_write_in = 1'b0; bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0;
    bus.branch_in = 1'b0;
    no_fwd();

    // 1. reset for two cycles, release with nothing offered
    tick(); tick();
    #1 chk("rst_in_ready_during", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    tick();
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("rst_store_data", bus.store_data, 32'd0);
    chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 2. plain ADD load, 1-cycle latency
    offer(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 1'b0, 4'b0010);
    bus.reg_write_in = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.reg_write_in = 1'b0;
    #1;
    chk("add_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_alu_a", bus.alu_a, 32'd5);
    chk("add_alu_b", bus.alu_b, 32'd7);
    chk("add_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
    chk("add_rd_out", {27'd0, bus.rd_out}, 32'd3);
    chk("add_reg_write", {31'd0, bus.reg_write}, 32'd1);

    // 3. forwarding priority on held rs1=x3 (stalled so it stays put)
    offer(5'd3, 32'h11, 5'd0, 32'h22, 32'd0, 5'd1, 1'b0, 4'b0000);
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exmem_rd = 5'd3; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hAA;
    bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBB;
    #1 chk("fwd_exmem_prio", bus.alu_a, 32'hAA);
    bus.exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb", bus.alu_a, 32'hBB);
    no_fwd();
    #1 chk("fwd_none_held", bus.alu_a, 32'h11);
    tick();
    // rs1=x0 with both producers targeting x0
    bus.out_ready = 1'b1;
    offer(5'd0, 32'h33, 5'd0, 32'h44, 32'd0, 5'd2, 1'b0, 4'b0001);
    tick();
    bus.in_valid = 1'b0;
    bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hAA;
    bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBB;
    #1;
    chk("fwd_x0_alu_a", bus.alu_a, 32'h33);
    chk("fwd_x0_store", bus.store_data, 32'h44);
    no_fwd();

    // 4. stall with a one-cycle MEM/WB producer on rs2=x4
    offer(5'd5, 32'd1, 5'd4, 32'h99, 32'hFFFF, 5'd6, 1'b0, 4'b0010);
    tick();
    offer(5'd7, 32'd2, 5'd8, 32'd3, 32'd0, 5'd9, 1'b0, 4'b0110);
    bus.out_ready = 1'b0;
    bus.memwb_rd = 5'd4; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h1234;
    #1;
    chk("stall_c1_alu_b", bus.alu_b, 32'h1234);
    chk("stall_c1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.memwb_reg_write = 1'b0; bus.memwb_result = 32'h0;
    #1;
    chk("stall_c2_alu_b", bus.alu_b, 32'h1234);
    chk("stall_c2_store", bus.store_data, 32'h1234);
    chk("stall_c2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    #1;
    chk("stall_c3_alu_b", bus.alu_b, 32'h1234);
    chk("stall_c3_store", bus.store_data, 32'h1234);
    chk("stall_c3_rd_out", {27'd0, bus.rd_out}, 32'd6);
    chk("stall_c3_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 chk("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    #1 chk("stall_consumed", {31'd0, bus.out_valid}, 32'd0);

    // 5. flush drops both held entry and the offered one
    bus.out_ready = 1'b0;
    offer(5'd1, 32'd10, 5'd2, 32'd20, 32'd0, 5'd7, 1'b0, 4'b0001);
    tick();
    offer(5'd3, 32'd30, 5'd4, 32'd40, 32'd0, 5'd8, 1'b0, 4'b0110);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_rd_kept", {27'd0, bus.rd_out}, 32'd7);
    chk("flush_ctrl_kept", {28'd0, bus.alu_ctrl}, 32'h1);
    offer(5'd3, 32'd30, 5'd4, 32'd40, 32'd0, 5'd8, 1'b0, 4'b0110);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("reload_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("reload_rd", {27'd0, bus.rd_out}, 32'd8);
    chk("reload_alu_a", bus.alu_a, 32'd30);

    // reset in the middle of a stall wins
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_stall_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_stall_alu_a", bus.alu_a, 32'd0);
    chk("rst_mid_stall_rd", {27'd0, bus.rd_out}, 32'd0);

    // 6. back-to-back immediates, no bubbles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(5'd1, 32'd0, 5'd2, 32'hDEAD, i, 5'd5, 1'b1, 4'b0010);
      tick();
      #1;
      chk($sformatf("b2b_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("b2b_alu_b_%0d", i), bus.alu_b, i);
      chk($sformatf("b2b_store_%0d", i), bus.store_data, 32'hDEAD);
    end
    bus.in_valid = 1'b0;
    tick();
    #1 chk("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
